// File: rtl/adc_scan_sched_if.sv
// ---------------------------------------------------------------------------
// adc_scan_sched_if
// Conversion handshake between the scan scheduler and the shared SPI ADC
// transaction engine.
//   conv_start : 1-cycle pulse, scheduler -> engine, start a conversion
//   conv_chan  : channel to convert, stable from start until done/abort
//   conv_done  : 1-cycle pulse, engine -> scheduler, conv_data valid
//   conv_data  : conversion result
// Modports: master = scheduler side, slave = engine side.
// ---------------------------------------------------------------------------
interface adc_scan_sched_if #(
    parameter int CHAN_W = 3,
    parameter int N      = 10
);
    logic              conv_start;
    logic [CHAN_W-1:0] conv_chan;
    logic              conv_done;
    logic [N-1:0]      conv_data;

    modport master (
        output conv_start,
        output conv_chan,
        input  conv_done,
        input  conv_data
    );

    modport slave (
        input  conv_start,
        input  conv_chan,
        output conv_done,
        output conv_data
    );
endinterface

// File: rtl/adc_scan_sched.sv
// ---------------------------------------------------------------------------
// adc_scan_sched
// Sequences conversions on the shared SPI ADC engine. Round-robins over the
// enabled channel set while scan_run is high, serves a one-shot requester
// ahead of the scan, and keeps the latest result per channel.
//
// Ports:
//   SCLK, reset_n        clock, asynchronous active-low reset
//   scan_run             level, enables the background scan
//   chan_en              per-channel scan enable (sampled in SELECT)
//   oneshot_req/_chan    one-shot request (held until ack) and its channel
//   oneshot_ack          1-cycle pulse, one-shot finished (stored or aborted)
//   eng                  conversion handshake to the SPI engine (master)
//   result/result_valid  per-channel latest result and validity
//   update_strobe/_chan  1-cycle pulse after a result write, channel written
//   timeout_err          1-cycle pulse on WAIT timeout or bad one-shot channel
//   busy                 scheduler not idle
// ---------------------------------------------------------------------------
module adc_scan_sched #(
    parameter int CHANNELS = 8,
    parameter int N        = 10,
    parameter int CHAN_W   = 3,
    parameter int TIMEOUT  = 64
) (
    input  logic                       SCLK,
    input  logic                       reset_n,
    input  logic                       scan_run,
    input  logic [CHANNELS-1:0]        chan_en,
    input  logic                       oneshot_req,
    input  logic [CHAN_W-1:0]          oneshot_chan,
    output logic                       oneshot_ack,
    adc_scan_sched_if.master           eng,
    output logic [CHANNELS-1:0][N-1:0] result,
    output logic [CHANNELS-1:0]        result_valid,
    output logic                       update_strobe,
    output logic [CHAN_W-1:0]          update_chan,
    output logic                       timeout_err,
    output logic                       busy
);

    localparam int unsigned       CH_U      = CHANNELS;
    localparam int                CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CHAN_W-1:0] LAST_INIT = CHAN_W'(CHANNELS - 1);

    // S_REJECT: one cycle to pulse ack/error for an out-of-range one-shot
    // channel without starting a conversion.
    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_WAIT,
        S_STORE,
        S_REJECT
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [CHAN_W-1:0] r_cur;
    logic [CHAN_W-1:0] r_last;
    logic              r_is_oneshot;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_os_bad;
    logic              w_scan_found;
    logic [CHAN_W-1:0] w_scan_chan;
    logic              w_timeout;
    int unsigned       w_best_d;
    logic [31:0]       w_last_u;

    assign w_last_u = 32'(r_last);
    assign w_os_bad = (32'(oneshot_chan) >= CH_U);
    assign w_timeout = (r_state == S_WAIT) && !eng.conv_done && (r_cnt == CNT_LAST);

    // Next scan channel: the enabled channel at the smallest forward distance
    // from the one after r_last. Distance 0 is r_last+1, and r_last itself
    // sits at distance CHANNELS-1, so a lone enabled channel is reselected.
    always_comb begin
        w_scan_found = 1'b0;
        w_scan_chan  = '0;
        w_best_d     = CH_U;
        for (int unsigned j = 0; j < CH_U; j++) begin
            if (scan_run && chan_en[j] &&
                (((j + CH_U - 1 - w_last_u) % CH_U) < w_best_d)) begin
                w_best_d     = (j + CH_U - 1 - w_last_u) % CH_U;
                w_scan_found = 1'b1;
                w_scan_chan  = CHAN_W'(j);
            end
        end
    end

    // State register
    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (oneshot_req || (scan_run && (|chan_en))) begin
                    w_next = S_SELECT;
                end
            end
            S_SELECT: begin
                if (oneshot_req) begin
                    w_next = w_os_bad ? S_REJECT : S_ISSUE;
                end else if (w_scan_found) begin
                    w_next = S_ISSUE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (eng.conv_done) begin
                    w_next = S_STORE;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = S_IDLE;
                end
            end
            S_STORE:  w_next = S_IDLE;
            S_REJECT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        eng.conv_start = (r_state == S_ISSUE);
        eng.conv_chan  = r_cur;
        update_strobe  = (r_state == S_STORE);
        update_chan    = (r_state == S_STORE) ? r_cur : '0;
        oneshot_ack    = ((r_state == S_STORE) && r_is_oneshot) ||
                         (r_state == S_REJECT) ||
                         (w_timeout && r_is_oneshot);
        timeout_err    = (r_state == S_REJECT) || w_timeout;
        busy           = (r_state != S_IDLE);
    end

    // Channel bookkeeping, timeout counter and result table
    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_cur        <= '0;
            r_last       <= LAST_INIT;
            r_is_oneshot <= 1'b0;
            r_cnt        <= '0;
            result       <= '0;
            result_valid <= '0;
        end else begin
            case (r_state)
                S_SELECT: begin
                    if (oneshot_req) begin
                        r_cur        <= oneshot_chan;
                        r_is_oneshot <= 1'b1;
                    end else begin
                        r_is_oneshot <= 1'b0;
                        if (w_scan_found) begin
                            r_cur <= w_scan_chan;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    // conv_done on the expiry cycle still stores
                    if (eng.conv_done) begin
                        for (int unsigned i = 0; i < CH_U; i++) begin
                            if (r_cur == CHAN_W'(i)) begin
                                result[i]       <= eng.conv_data;
                                result_valid[i] <= 1'b1;
                            end
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        for (int unsigned i = 0; i < CH_U; i++) begin
                            if (r_cur == CHAN_W'(i)) begin
                                result_valid[i] <= 1'b0;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STORE: begin
                    // One-shots leave the scan position untouched
                    if (!r_is_oneshot) begin
                        r_last <= r_cur;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_sched.sv
// ---------------------------------------------------------------------------
// tb_adc_scan_sched
// Directed bench for adc_scan_sched. Main DUT: 8 channels, TIMEOUT=16, with a
// behavioural engine answering 3 cycles after conv_start with 0x100+chan.
// Second DUT: 4 channels, TIMEOUT=8, engine never answers (one-shot paths).
// Inputs change and outputs are sampled on the falling edge; the engine
// model acts 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_adc_scan_sched;

    localparam int TO  = 16;
    localparam int TO4 = 8;

    logic              SCLK;
    logic              reset_n;
    logic              scan_run;
    logic [7:0]        chan_en;
    logic              oneshot_req;
    logic [2:0]        oneshot_chan;
    logic              oneshot_ack;
    logic [7:0][9:0]   result;
    logic [7:0]        result_valid;
    logic              update_strobe;
    logic [2:0]        update_chan;
    logic              timeout_err;
    logic              busy;

    logic              req4;
    logic [2:0]        chan4;
    logic              ack4;
    logic [3:0][9:0]   result4;
    logic [3:0]        valid4;
    logic              strobe4;
    logic [2:0]        uchan4;
    logic              terr4;
    logic              busy4;

    int                total;
    int                bad;
    logic              eng_on;
    int                rem;
    logic [2:0]        eng_ch;

    adc_scan_sched_if #(.CHAN_W(3), .N(10)) eng_if ();
    adc_scan_sched_if #(.CHAN_W(3), .N(10)) eng4_if ();

    adc_scan_sched #(.CHANNELS(8), .N(10), .CHAN_W(3), .TIMEOUT(TO)) u_dut (
        .SCLK          (SCLK),
        .reset_n       (reset_n),
        .scan_run      (scan_run),
        .chan_en       (chan_en),
        .oneshot_req   (oneshot_req),
        .oneshot_chan  (oneshot_chan),
        .oneshot_ack   (oneshot_ack),
        .eng           (eng_if),
        .result        (result),
        .result_valid  (result_valid),
        .update_strobe (update_strobe),
        .update_chan   (update_chan),
        .timeout_err   (timeout_err),
        .busy          (busy)
    );

    adc_scan_sched #(.CHANNELS(4), .N(10), .CHAN_W(3), .TIMEOUT(TO4)) u_dut4 (
        .SCLK          (SCLK),
        .reset_n       (reset_n),
        .scan_run      (1'b0),
        .chan_en       (4'b0000),
        .oneshot_req   (req4),
        .oneshot_chan  (chan4),
        .oneshot_ack   (ack4),
        .eng           (eng4_if),
        .result        (result4),
        .result_valid  (valid4),
        .update_strobe (strobe4),
        .update_chan   (uchan4),
        .timeout_err   (terr4),
        .busy          (busy4)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    // Engine model: conv_done 3 cycles after conv_start while eng_on is set
    initial begin
        eng_if.conv_done  = 1'b0;
        eng_if.conv_data  = '0;
        eng4_if.conv_done = 1'b0;
        eng4_if.conv_data = '0;
        rem    = 0;
        eng_ch = '0;
        forever begin
            @(posedge SCLK);
            #1;
            eng_if.conv_done = 1'b0;
            if (rem > 0) begin
                rem = rem - 1;
                if (rem == 0) begin
                    eng_if.conv_done = 1'b1;
                    eng_if.conv_data = 10'h100 + 10'(eng_ch);
                end
            end
            if (eng_if.conv_start && eng_on) begin
                rem    = 3;
                eng_ch = eng_if.conv_chan;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input int budget, output int n, output logic [2:0] ch, output int acks);
        n    = 0;
        acks = 0;
        do begin
            @(negedge SCLK);
            n++;
            acks += int'(oneshot_ack);
        end while (!eng_if.conv_start && n < budget);
        ch = eng_if.conv_chan;
    endtask

    // which: 0 = oneshot_ack, 1 = timeout_err
    task automatic wait_sig(input int budget, input int which, output int n);
        n = 0;
        do begin
            @(negedge SCLK);
            n++;
        end while (!((which == 0) ? oneshot_ack : timeout_err) && n < budget);
    endtask

    initial begin
        int          n;
        int          acks;
        int          s_cnt;
        int          b_cnt;
        logic [2:0]  ch;

        total        = 0;
        bad          = 0;
        eng_on       = 1'b1;
        reset_n      = 1'b0;
        scan_run     = 1'b0;
        chan_en      = '0;
        oneshot_req  = 1'b0;
        oneshot_chan = '0;
        req4         = 1'b0;
        chan4        = '0;

        // Reset state
        repeat (2) @(negedge SCLK);
        chk("rst_busy", busy, 1'b0);
        chk("rst_start", eng_if.conv_start, 1'b0);
        chk("rst_chan", eng_if.conv_chan, 3'd0);
        chk("rst_strobe", update_strobe, 1'b0);
        chk("rst_terr", timeout_err, 1'b0);
        chk("rst_ack", oneshot_ack, 1'b0);
        chk("rst_result", result, 80'h0);
        chk("rst_valid", result_valid, 8'h00);

        // Scan over channels 0 and 2; first conversion timing
        reset_n  = 1'b1;
        scan_run = 1'b1;
        chan_en  = 8'b0000_0101;
        @(negedge SCLK);
        chk("sel_busy", busy, 1'b1);
        chk("sel_nostart", eng_if.conv_start, 1'b0);
        @(negedge SCLK);
        chk("t2_start", eng_if.conv_start, 1'b1);
        chk("t2_chan", eng_if.conv_chan, 3'd0);
        @(negedge SCLK);
        chk("start_1cyc", eng_if.conv_start, 1'b0);
        repeat (2) @(negedge SCLK);
        chk("done_cyc_nostrobe", update_strobe, 1'b0);
        @(negedge SCLK);
        chk("k1_strobe", update_strobe, 1'b1);
        chk("k1_uchan", update_chan, 3'd0);
        chk("k1_res0", result[0], 10'h100);
        chk("k1_valid", result_valid, 8'h01);
        wait_start(20, n, ch, acks);
        chk("seq2_lat", n, 3);
        chk("seq2_chan", ch, 3'd2);
        wait_start(20, n, ch, acks);
        chk("seq3_lat", n, 7);
        chk("seq3_chan", ch, 3'd0);
        wait_start(20, n, ch, acks);
        chk("seq4_lat", n, 7);
        chk("seq4_chan", ch, 3'd2);
        repeat (4) @(negedge SCLK);
        chk("seq4_strobe", update_strobe, 1'b1);
        chk("seq4_uchan", update_chan, 3'd2);
        chk("seq4_res2", result[2], 10'h102);
        chk("seq4_valid", result_valid, 8'h05);

        // One-shot on ch5 arriving during a ch0 conversion
        chan_en = 8'b0000_0011;
        wait_start(20, n, ch, acks);
        chk("os_pre_lat", n, 3);
        chk("os_pre_chan", ch, 3'd0);
        @(negedge SCLK);
        oneshot_req  = 1'b1;
        oneshot_chan = 3'd5;
        wait_start(20, n, ch, acks);
        chk("os_lat", n, 6);
        chk("os_chan", ch, 3'd5);
        chk("os_noearlyack", acks, 0);
        wait_sig(20, 0, n);
        chk("os_ack_lat", n, 4);
        chk("os_res5", result[5], 10'h105);
        chk("os_valid", result_valid, 8'h25);
        chk("os_uchan", update_chan, 3'd5);
        oneshot_req = 1'b0;
        wait_start(20, n, ch, acks);
        chk("os_resume_lat", n, 3);
        chk("os_resume_chan", ch, 3'd1);
        chk("os_single_ack", acks, 0);

        // Single enabled channel ch3: one store, then a timeout
        chan_en = 8'b0000_1000;
        wait_start(20, n, ch, acks);
        chk("to_pre_lat", n, 7);
        chk("to_pre_chan", ch, 3'd3);
        eng_on = 1'b0;
        repeat (4) @(negedge SCLK);
        chk("to_pre_res3", result[3], 10'h103);
        chk("to_pre_valid", result_valid, 8'h2F);
        wait_start(20, n, ch, acks);
        chk("to_resel_lat", n, 3);
        chk("to_resel_chan", ch, 3'd3);
        wait_sig(TO + 10, 1, n);
        chk("to_lat", n, TO);
        chk("to_noack", oneshot_ack, 1'b0);
        eng_on = 1'b1;
        @(negedge SCLK);
        chk("to_valid_clr", result_valid, 8'h27);
        chk("to_pulse_1cyc", timeout_err, 1'b0);
        wait_start(20, n, ch, acks);
        chk("to_retry_lat", n, 2);
        chk("to_retry_chan", ch, 3'd3);

        // Reset during WAIT, stray conv_done afterwards
        @(negedge SCLK);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", result_valid, 8'h00);
        chk("mid_rst_result", result, 80'h0);
        chk("mid_rst_chan", eng_if.conv_chan, 3'd0);
        chk("mid_rst_terr", timeout_err, 1'b0);
        @(negedge SCLK);
        reset_n  = 1'b1;
        scan_run = 1'b0;
        chan_en  = '0;
        s_cnt = 0;
        b_cnt = 0;
        repeat (5) begin
            @(negedge SCLK);
            s_cnt += int'(update_strobe);
            b_cnt += int'(busy);
        end
        chk("stray_strobe", s_cnt, 0);
        chk("stray_busy", b_cnt, 0);
        chk("stray_valid", result_valid, 8'h00);

        // Out-of-range one-shot channel on the 4-channel instance
        req4  = 1'b1;
        chan4 = 3'd7;
        @(negedge SCLK);
        chk("bad_sel_busy", busy4, 1'b1);
        chk("bad_sel_nostart", eng4_if.conv_start, 1'b0);
        @(negedge SCLK);
        chk("bad_terr", terr4, 1'b1);
        chk("bad_ack", ack4, 1'b1);
        chk("bad_nostart", eng4_if.conv_start, 1'b0);
        req4 = 1'b0;
        @(negedge SCLK);
        chk("bad_idle", busy4, 1'b0);
        chk("bad_ack_1cyc", ack4, 1'b0);

        // Valid one-shot that times out: ack together with timeout_err
        req4  = 1'b1;
        chan4 = 3'd2;
        repeat (2) @(negedge SCLK);
        chk("os4_start", eng4_if.conv_start, 1'b1);
        chk("os4_chan", eng4_if.conv_chan, 3'd2);
        repeat (TO4 - 1) @(negedge SCLK);
        chk("os4_pre_terr", terr4, 1'b0);
        @(negedge SCLK);
        chk("os4_terr", terr4, 1'b1);
        chk("os4_ack", ack4, 1'b1);
        req4 = 1'b0;
        @(negedge SCLK);
        chk("os4_idle", busy4, 1'b0);
        chk("os4_valid", valid4, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
